// File: rtl/in_port_mux_if.sv
// in_port_mux_if: external input ports, core read request and read-data
// return path of the CPU-side input multiplexer.
//   master : board/core side (drives ports, strobes, select, read enable)
//   slave  : in_port_mux side (returns data_in and irq)
interface in_port_mux_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] port0_in;
    logic             port0_stb;
    logic [WIDTH-1:0] port1_in;
    logic             port1_stb;
    logic [WIDTH-1:0] port2_in;
    logic             port2_stb;
    logic [3:0]       port_sel;
    logic             in_read_en;
    logic [WIDTH-1:0] data_in;
    logic             irq;

    modport master (
        output port0_in, port0_stb,
        output port1_in, port1_stb,
        output port2_in, port2_stb,
        output port_sel, in_read_en,
        input  data_in, irq
    );

    modport slave (
        input  port0_in, port0_stb,
        input  port1_in, port1_stb,
        input  port2_in, port2_stb,
        input  port_sel, in_read_en,
        output data_in, irq
    );
endinterface

// File: rtl/in_port_mux.sv
// in_port_mux: captures three external input ports on (possibly asynchronous)
// strobe rising edges, keeps a ready/overrun flag per port, and returns the
// selected port word or the status word on a core read (1-cycle latency).
// Status word: {zeros, ovr[2:0] at 6:4, 1'b0 at 3, rdy[2:0] at 2:0}.
// Optional macro IN_PORT_MUX_IRQ_EN: irq is a registered OR of the ready
// flags; when undefined irq is tied low.
module in_port_mux #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic          CLK,
    input  logic          RST_N,
    in_port_mux_if.slave  bus
);

    localparam int unsigned NPORTS = 3;

    logic [WIDTH-1:0]       port_data [NPORTS];
    logic [NPORTS-1:0]      stb;

    logic [SYNC_STAGES-1:0] sync_q [NPORTS];
    logic [NPORTS-1:0]      prev_q;
    logic [NPORTS-1:0]      cap;

    logic [WIDTH-1:0]       hold_q [NPORTS];
    logic [WIDTH-1:0]       hold_d [NPORTS];
    logic [NPORTS-1:0]      rdy_q, rdy_d;
    logic [NPORTS-1:0]      ovr_q, ovr_d;
    logic [WIDTH-1:0]       data_q, data_d;
    logic [WIDTH-1:0]       status;
    logic [NPORTS-1:0]      rd_hit;
    logic                   rd_status;

    assign port_data[0] = bus.port0_in;
    assign port_data[1] = bus.port1_in;
    assign port_data[2] = bus.port2_in;
    assign stb          = {bus.port2_stb, bus.port1_stb, bus.port0_stb};

    assign status = {{(WIDTH-7){1'b0}}, ovr_q, 1'b0, rdy_q};

    // Strobe synchronizers plus one history flop per port for edge detection
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int unsigned k = 0; k < NPORTS; k++) begin
                sync_q[k] <= '0;
            end
            prev_q <= '0;
        end else begin
            for (int unsigned k = 0; k < NPORTS; k++) begin
                sync_q[k] <= {sync_q[k][SYNC_STAGES-2:0], stb[k]};
                prev_q[k] <= sync_q[k][SYNC_STAGES-1];
            end
        end
    end

    // Rising edge of each synchronized strobe marks the capture cycle
    always_comb begin
        cap = '0;
        for (int unsigned k = 0; k < NPORTS; k++) begin
            cap[k] = sync_q[k][SYNC_STAGES-1] & ~prev_q[k];
        end
    end

    // Next-state for holding registers, flags and read data
    always_comb begin
        rd_status = bus.in_read_en && (bus.port_sel == 4'd3);
        rd_hit    = '0;
        rdy_d     = rdy_q;
        ovr_d     = rd_status ? '0 : ovr_q;
        for (int unsigned k = 0; k < NPORTS; k++) begin
            rd_hit[k] = bus.in_read_en && (bus.port_sel == 4'(k));
            hold_d[k] = cap[k] ? port_data[k] : hold_q[k];
            // Read clears first so a same-edge capture wins; a same-edge
            // read also cancels the overrun that capture would raise.
            if (rd_hit[k]) begin
                rdy_d[k] = 1'b0;
            end
            if (cap[k]) begin
                rdy_d[k] = 1'b1;
                if (rdy_q[k] && !rd_hit[k]) begin
                    ovr_d[k] = 1'b1;
                end
            end
        end

        data_d = data_q;
        if (bus.in_read_en) begin
            case (bus.port_sel)
                4'd0:    data_d = hold_q[0];
                4'd1:    data_d = hold_q[1];
                4'd2:    data_d = hold_q[2];
                4'd3:    data_d = status;
                default: data_d = '0;
            endcase
        end
    end

    // State registers: holding words, flags and registered read data
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int unsigned k = 0; k < NPORTS; k++) begin
                hold_q[k] <= '0;
            end
            rdy_q  <= '0;
            ovr_q  <= '0;
            data_q <= '0;
        end else begin
            for (int unsigned k = 0; k < NPORTS; k++) begin
                hold_q[k] <= hold_d[k];
            end
            rdy_q  <= rdy_d;
            ovr_q  <= ovr_d;
            data_q <= data_d;
        end
    end

    assign bus.data_in = data_q;

`ifdef IN_PORT_MUX_IRQ_EN
    logic irq_q;

    // Interrupt follows any pending ready flag, one cycle behind
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= |rdy_q;
        end
    end

    assign bus.irq = irq_q;
`else
    assign bus.irq = 1'b0;
`endif

endmodule

// File: tb/tb_in_port_mux.sv
// tb_in_port_mux: directed, table-driven bench for in_port_mux plus
// hand-written sequences for capture latency, collisions, reset and irq.
module tb_in_port_mux;

`ifdef IN_PORT_MUX_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    in_port_mux_if #(.WIDTH(16)) bus ();

    in_port_mux #(.WIDTH(16), .SYNC_STAGES(2)) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit         is_read;
        logic [3:0] sel;
        logic [15:0] val;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs [21];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic set_port(input int p, input logic [15:0] v, input logic s);
        case (p)
            0: begin bus.port0_in = v; bus.port0_stb = s; end
            1: begin bus.port1_in = v; bus.port1_stb = s; end
            default: begin bus.port2_in = v; bus.port2_stb = s; end
        endcase
    endtask

    task automatic set_stb(input int p, input logic s);
        case (p)
            0: bus.port0_stb = s;
            1: bus.port1_stb = s;
            default: bus.port2_stb = s;
        endcase
    endtask

    task automatic cap(input int p, input logic [15:0] v);
        set_port(p, v, 1'b1);
        repeat (3) tick();
        set_stb(p, 1'b0);
        repeat (3) tick();
    endtask

    task automatic rd(input logic [3:0] sel, input logic [15:0] exp, input string name);
        bus.port_sel   = sel;
        bus.in_read_en = 1'b1;
        tick();
        bus.in_read_en = 1'b0;
        check(name, bus.data_in, exp);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        bus.port0_in = '0; bus.port0_stb = 1'b0;
        bus.port1_in = '0; bus.port1_stb = 1'b0;
        bus.port2_in = '0; bus.port2_stb = 1'b0;
        bus.port_sel = '0; bus.in_read_en = 1'b0;

        vecs[0]  = '{1'b0, 4'd1, 16'hBEEF, 16'h0000};
        vecs[1]  = '{1'b1, 4'd3, 16'h0000, 16'h0002};
        vecs[2]  = '{1'b1, 4'd1, 16'h0000, 16'hBEEF};
        vecs[3]  = '{1'b1, 4'd3, 16'h0000, 16'h0000};
        vecs[4]  = '{1'b0, 4'd0, 16'h1111, 16'h0000};
        vecs[5]  = '{1'b0, 4'd0, 16'h2222, 16'h0000};
        vecs[6]  = '{1'b1, 4'd3, 16'h0000, 16'h0011};
        vecs[7]  = '{1'b1, 4'd3, 16'h0000, 16'h0001};
        vecs[8]  = '{1'b1, 4'd0, 16'h0000, 16'h2222};
        vecs[9]  = '{1'b1, 4'd3, 16'h0000, 16'h0000};
        vecs[10] = '{1'b0, 4'd1, 16'hC0DE, 16'h0000};
        vecs[11] = '{1'b0, 4'd2, 16'h0BAD, 16'h0000};
        vecs[12] = '{1'b1, 4'd3, 16'h0000, 16'h0006};
        vecs[13] = '{1'b1, 4'd2, 16'h0000, 16'h0BAD};
        vecs[14] = '{1'b1, 4'd1, 16'h0000, 16'hC0DE};
        vecs[15] = '{1'b1, 4'd3, 16'h0000, 16'h0000};
        vecs[16] = '{1'b0, 4'd2, 16'h0F0F, 16'h0000};
        vecs[17] = '{1'b1, 4'd7, 16'h0000, 16'h0000};
        vecs[18] = '{1'b1, 4'd3, 16'h0000, 16'h0004};
        vecs[19] = '{1'b1, 4'd2, 16'h0000, 16'h0F0F};
        vecs[20] = '{1'b1, 4'd3, 16'h0000, 16'h0000};

        // Reset state
        tick(); tick();
        check("rst_data", bus.data_in, 16'h0000);
        check("rst_irq", {15'd0, bus.irq}, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Table-driven capture/read sequence
        for (int i = 0; i < 21; i++) begin
            if (vecs[i].is_read) begin
                rd(vecs[i].sel, vecs[i].exp, $sformatf("vec%0d", i));
            end else begin
                cap(int'(vecs[i].sel), vecs[i].val);
            end
        end

        // Capture latency: strobe sampled at edge 1, captured at edge 3
        set_port(0, 16'h1234, 1'b1);
        tick(); tick();
        bus.port_sel = 4'd3; bus.in_read_en = 1'b1;
        tick();
        check("lat_pre", bus.data_in, 16'h0000);
        tick();
        check("lat_post", bus.data_in, 16'h0001);
        bus.in_read_en = 1'b0;
        set_stb(0, 1'b0);
        rd(4'd0, 16'h1234, "lat_word");
        rd(4'd3, 16'h0000, "lat_clr");

        // Same-port capture and read on one edge (old hold 0F0F)
        set_port(2, 16'hA5A5, 1'b1);
        tick(); tick();
        bus.port_sel = 4'd2; bus.in_read_en = 1'b1;
        tick();
        check("coll_old", bus.data_in, 16'h0F0F);
        bus.port_sel = 4'd3;
        tick();
        check("coll_stat", bus.data_in, 16'h0004);
        bus.in_read_en = 1'b0;
        set_stb(2, 1'b0);
        rd(4'd2, 16'hA5A5, "coll_new");
        rd(4'd3, 16'h0000, "coll_clr");

        // Capture with status read on one edge: set wins over clear
        cap(1, 16'h1357);
        set_port(1, 16'h2468, 1'b1);
        tick(); tick();
        bus.port_sel = 4'd3; bus.in_read_en = 1'b1;
        tick();
        check("sc_pre", bus.data_in, 16'h0002);
        set_stb(1, 1'b0);
        tick();
        check("sc_ovr", bus.data_in, 16'h0022);
        tick();
        check("sc_clr", bus.data_in, 16'h0002);
        bus.in_read_en = 1'b0;
        rd(4'd1, 16'h2468, "sc_word");
        rd(4'd3, 16'h0000, "sc_flags");

        // Idle: data_in holds with read enable low
        rd(4'd1, 16'h2468, "idle_set");
        for (int i = 0; i < 10; i++) begin
            bus.port_sel = 4'(i);
            tick();
            check("idle_hold", bus.data_in, 16'h2468);
        end

        // Strobe held high: exactly one capture
        set_port(0, 16'h5555, 1'b1);
        repeat (5) tick();
        bus.port0_in = 16'h6666;
        repeat (15) tick();
        set_stb(0, 1'b0);
        repeat (3) tick();
        rd(4'd3, 16'h0001, "held_stat");
        rd(4'd0, 16'h5555, "held_word");
        rd(4'd3, 16'h0000, "held_clr");

        // Interrupt timing
        set_port(0, 16'h0042, 1'b1);
        tick(); tick(); tick();
        check("irq_rdy_edge", {15'd0, bus.irq}, 16'h0000);
        set_stb(0, 1'b0);
        tick();
        check("irq_set", {15'd0, bus.irq}, {15'd0, IRQ_ON});
        rd(4'd0, 16'h0042, "irq_word");
        check("irq_hold", {15'd0, bus.irq}, {15'd0, IRQ_ON});
        tick();
        check("irq_clr", {15'd0, bus.irq}, 16'h0000);

        // Asynchronous reset mid-capture
        cap(2, 16'h0777);
        rd(4'd1, 16'h2468, "prerst_word");
        set_port(1, 16'h7777, 1'b1);
        tick(); tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_data", bus.data_in, 16'h0000);
        check("arst_irq", {15'd0, bus.irq}, 16'h0000);
        set_stb(1, 1'b0);
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) tick();
        rd(4'd3, 16'h0000, "post_rst_stat");
        rd(4'd2, 16'h0000, "post_rst_hold");
        check("post_rst_irq", {15'd0, bus.irq}, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
